// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers, default thresholds and parameter checks for FIFO variants
package fifo_pkg;

  localparam int DEFAULT_AEMPTY_THRESH = 2;

  function automatic int default_afull_thresh(input int depth);
    return depth - 2;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int afull, input int aempty);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - producer/consumer bus of sync_fifo_prog
interface sync_fifo_prog_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = cnt_width(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port register array, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds and sticky errors; SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = default_afull_thresh(DEPTH),
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_THRESH);

  if (!fifo_params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
    $fatal(1, "sync_fifo_prog: illegal DEPTH or threshold parameters");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_nxt;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, udf_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && !empty_q;

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);
  end

  // Flags are derived from count_nxt so they line up with count every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count_q  <= count_nxt;
      full_q   <= (count_nxt == FULL_CNT);
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= AF_CNT);
      aempty_q <= (count_nxt <= AE_CNT);
      ovf_q    <= (bus.wr_en && full_q) || (ovf_q && !bus.clr_err);
      udf_q    <= (bus.rd_en && empty_q) || (udf_q && !bus.clr_err);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = rd_data;
  assign bus.rd_valid = !empty_q;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) dout_q <= rd_data;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.rd_valid = rvalid_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - randomized self-checking bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;
  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_prog #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count", 32'(bus.count), 32'(n));
    check("full", 32'(bus.full), 32'(n == DEPTH));
    check("empty", 32'(bus.empty), 32'(n == 0));
    check("almost_full", 32'(bus.almost_full), 32'(n >= AFULL));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AEMPTY));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", 32'(bus.rd_valid), 32'(n != 0));
    if (n != 0) check("data_out_fwft", 32'(bus.data_out), 32'(q[0]));
`else
    check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    check("data_out", 32'(bus.data_out), 32'(m_dout));
`endif
  endtask

  // One clock: drive at negedge, model the accepted transfers at posedge, check at next negedge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit was_full, was_empty;
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    bus.clr_err = c;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_valid = 1'b0;
    if (r && !was_empty) begin
      m_dout  = q.pop_front();
      m_valid = 1'b1;
    end
    if (w && !was_full) q.push_back(d);
    m_ovf = (w && was_full) || (m_ovf && !c);
    m_udf = (r && was_empty) || (m_udf && !c);
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  initial begin
    int pw;
    bus.wr_en   = 1'b0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0);

    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'hAA, 0, 0);
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    cycle(1, 8'h55, 1, 0);
    cycle(0, 8'h00, 1, 1);

    for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom), 1, 0);
    while (q.size() < DEPTH) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'hC3, 1, 0);
    cycle(0, 8'h00, 0, 1);

    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 90;
      for (int i = 0; i < 100; i++)
        cycle($urandom_range(0, 99) < pw, 8'($urandom),
              $urandom_range(0, 99) < (100 - pw) + 10, $urandom_range(0, 15) == 0);
    end

    while (q.size() > 0) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h30 + i), 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'h7E, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
